// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider latency, sideband flags and divide-by-zero constant
package div_pkg;

  // Wide enough for any supported DATA_W; users take the low DATA_W bits.
  localparam logic [63:0] DZ_QUOTIENT = '1;

  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic dz;
  } div_flags_t;

  function automatic int div_lat(input int data_w, input int opers_per_stage);
    return data_w / opers_per_stage;
  endfunction

endpackage

// File: rtl/div_sideband_dly.sv
// rtl/div_sideband_dly.sv - DEPTH-deep valid+payload shift register, valid bits reset
module div_sideband_dly #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign valid_o = valid_i;
      assign data_o  = data_i;
    end else begin : g_dly
      logic [DEPTH-1:0] vld;
      logic [W-1:0]     dat [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= '0;
        end else begin
          vld[0] <= valid_i;
          for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
        end
      end

      // Payload is qualified by vld, so it needs no reset.
      always_ff @(posedge clk) begin
        dat[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
      end

      assign valid_o = vld[DEPTH-1];
      assign data_o  = dat[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/div_pipe_post.sv
// rtl/div_pipe_post.sv - signed/zero-divisor correction and result register after div_pipe
module div_pipe_post
  import div_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int OPERS_PER_STAGE = 8,
  localparam int PIPE_LAT       = div_lat(DATA_W, OPERS_PER_STAGE),
  localparam int CNT_W          = $clog2(PIPE_LAT + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [DATA_W-1:0] quotient_raw_i,
  input  logic [DATA_W-1:0] remainder_raw_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_zero_o,
  output logic [CNT_W-1:0]  inflight_o
);

  localparam int SB_W = $bits(div_flags_t) + DATA_W;

  div_flags_t        flags_in, flags_out;
  logic [SB_W-1:0]   sb_in, sb_out;
  logic [DATA_W-1:0] dvd_out;
  logic              dly_valid;

  always_comb begin
    flags_in       = '0;
    flags_in.q_neg = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
    flags_in.r_neg = signed_i & dividend_i[DATA_W-1];
    flags_in.dz    = (divisor_i == '0);
  end

  assign sb_in              = {flags_in, dividend_i};
  assign {flags_out, dvd_out} = sb_out;

  div_sideband_dly #(
    .DEPTH (PIPE_LAT),
    .W     (SB_W)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (sb_in),
    .valid_o (dly_valid),
    .data_o  (sb_out)
  );

  // Most-negative / -1 falls out naturally: raw quotient is already 2^(W-1), q_neg = 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      valid_o <= dly_valid;
      if (dly_valid) begin
        div_zero_o <= flags_out.dz;
        if (flags_out.dz) begin
          quotient_o  <= DZ_QUOTIENT[DATA_W-1:0];
          remainder_o <= dvd_out;
        end else begin
          quotient_o  <= flags_out.q_neg ? -quotient_raw_i  : quotient_raw_i;
          remainder_o <= flags_out.r_neg ? -remainder_raw_i : remainder_raw_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_o <= '0;
    end else begin
      case ({valid_i, valid_o})
        2'b10:   inflight_o <= inflight_o + 1'b1;
        2'b01:   inflight_o <= inflight_o - 1'b1;
        default: inflight_o <= inflight_o;
      endcase
    end
  end

endmodule

// File: tb/tb_div_pipe_post.sv
// tb/tb_div_pipe_post.sv - randomized self-checking bench for div_pipe_post
module tb_div_pipe_post;
  import div_pkg::*;

  localparam int DW   = 32;
  localparam int OPS  = 8;
  localparam int LAT  = div_lat(DW, OPS);
  localparam int CW   = $clog2(LAT + 2);
  localparam int NCYC = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          signed_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic [DW-1:0] quotient_raw_i;
  logic [DW-1:0] remainder_raw_i;
  logic          valid_o;
  logic [DW-1:0] quotient_o;
  logic [DW-1:0] remainder_o;
  logic          div_zero_o;
  logic [CW-1:0] inflight_o;

  div_pipe_post #(.DATA_W(DW), .OPERS_PER_STAGE(OPS)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .signed_i        (signed_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .quotient_raw_i  (quotient_raw_i),
    .remainder_raw_i (remainder_raw_i),
    .valid_o         (valid_o),
    .quotient_o      (quotient_o),
    .remainder_o     (remainder_o),
    .div_zero_o      (div_zero_o),
    .inflight_o      (inflight_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Schedule of stimulus, one entry per cycle.
  logic          rst_c [NCYC];
  logic          op_v  [NCYC];
  logic          op_s  [NCYC];
  logic [DW-1:0] op_a  [NCYC];
  logic [DW-1:0] op_b  [NCYC];
  logic          live  [NCYC];

  // Architectural result: RISC-V division semantics in 64-bit arithmetic.
  task automatic ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                            output logic [DW-1:0] q, output logic [DW-1:0] r, output logic dz);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
      end
      lq = sa / sb; lr = sa % sb;
      q = lq[DW-1:0]; r = lr[DW-1:0]; dz = 1'b0;
    end
  endtask

  // Stand-in for div_pipe: unsigned divide of magnitudes.
  task automatic raw_result(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                            output logic [DW-1:0] q, output logic [DW-1:0] r);
    logic [DW-1:0] ua, ub;
    ua = (s && a[DW-1]) ? -a : a;
    ub = (s && b[DW-1]) ? -b : b;
    if (ub == 0) begin
      q = $urandom; r = $urandom;
    end else begin
      q = ua / ub; r = ua % ub;
    end
  endtask

  function automatic logic [DW-1:0] pick_operand(input bit divisor);
    case ($urandom_range(0, 9))
      0:       return divisor ? 32'h0 : 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return divisor ? 32'h0 : 32'h1;
      4, 5:    return DW'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  task automatic put_op(input int c, input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_v[c] = 1'b1; op_s[c] = s; op_a[c] = a; op_b[c] = b;
  endtask

  logic [DW-1:0] exp_q, exp_r, rq, rr;
  logic          exp_dz, edz, exp_v;
  int            n_inf, oc, c0;

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      rst_c[i] = (i < 3); op_v[i] = 1'b0; op_s[i] = 1'b0;
      op_a[i] = '0; op_b[i] = '0; live[i] = 1'b0;
    end
    put_op(5,  1'b0, 32'd100, 32'd7);
    put_op(12, 1'b1, -32'd100, 32'd7);
    put_op(13, 1'b1, 32'd100, -32'd7);
    put_op(14, 1'b1, 32'h1234_5678, 32'h0);
    put_op(15, 1'b0, 32'h1234_5678, 32'h0);
    put_op(16, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    put_op(17, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) put_op(40 + i, 1'b0, DW'(i), 32'd3);
    put_op(60, 1'b0, 32'd50, 32'd5);
    put_op(61, 1'b1, -32'd9, 32'd2);
    put_op(62, 1'b0, 32'd77, 32'd7);
    rst_c[62] = 1'b1;
    put_op(64, 1'b1, 32'd1000, -32'd3);
    for (int i = 80; i < NCYC - 20; i++) begin
      if ($urandom_range(0, 3) != 0)
        put_op(i, 1'($urandom), pick_operand(1'b0), pick_operand(1'b1));
      if ($urandom_range(0, 59) == 0) rst_c[i] = 1'b1;
    end

    exp_q = '0; exp_r = '0; exp_dz = 1'b0;
    for (int t = 0; t < NCYC; t++) begin
      cyc = t;
      rst = rst_c[t]; valid_i = op_v[t]; signed_i = op_s[t];
      dividend_i = op_v[t] ? op_a[t] : $urandom;
      divisor_i  = op_v[t] ? op_b[t] : $urandom;
      c0 = t - LAT;
      if (c0 >= 0 && op_v[c0]) raw_result(op_a[c0], op_b[c0], op_s[c0], rq, rr);
      else begin rq = $urandom; rr = $urandom; end
      quotient_raw_i = rq; remainder_raw_i = rr;

      @(posedge clk);
      #1;
      cyc = t + 1;
      if (rst_c[t]) begin
        for (int c = 0; c <= t; c++) live[c] = 1'b0;
        exp_q = '0; exp_r = '0; exp_dz = 1'b0;
      end else begin
        live[t] = op_v[t];
      end

      oc = t + 1 - (LAT + 1);
      exp_v = (oc >= 0) && live[oc];
      if (exp_v) ref_result(op_a[oc], op_b[oc], op_s[oc], exp_q, exp_r, edz);
      if (exp_v) exp_dz = edz;

      n_inf = 0;
      for (int c = t - LAT; c <= t; c++) if (c >= 0 && live[c]) n_inf++;

      chk("valid_o",     64'(valid_o),     64'(exp_v));
      chk("quotient_o",  64'(quotient_o),  64'(exp_q));
      chk("remainder_o", 64'(remainder_o), 64'(exp_r));
      chk("div_zero_o",  64'(div_zero_o),  64'(exp_dz));
      chk("inflight_o",  64'(inflight_o),  64'(n_inf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
